// File: rtl/systolic_feeder_i.sv
// rtl/systolic_feeder_i.sv - activation vector feeder for the systolic array input skew loader; optional SYSTOLIC_FEEDER_REPEAT_EN
`ifndef PE_ROW
`define PE_ROW 8
`endif
`ifndef BIT_DATA
`define BIT_DATA 8
`endif

module systolic_feeder_i #(
    parameter int ADDR_BITS = 8,
    parameter int FLUSH_LEN = 14
) (
    input  logic                            CLK,
    input  logic                            RSTn,
    input  logic                            i_Start,
    input  logic [ADDR_BITS-1:0]            i_Base_Addr,
    input  logic [ADDR_BITS:0]              i_Len,
`ifdef SYSTOLIC_FEEDER_REPEAT_EN
    input  logic [3:0]                      i_Repeat,
`endif
    output logic                            o_Rd_En,
    output logic [ADDR_BITS-1:0]            o_Rd_Addr,
    input  logic [`PE_ROW*`BIT_DATA-1:0]    i_Rd_Data,
    output logic [`PE_ROW*`BIT_DATA-1:0]    o_Data_I_In,
    output logic                            o_Valid,
    output logic                            o_Busy,
    output logic                            o_Done
);

    // The flush phase covers the two-cycle read/register pipeline so that
    // FLUSH_LEN all-zero vectors follow the last data vector before done.
    localparam int FLUSH_CYC = FLUSH_LEN + 2;
    localparam int FW        = $clog2(FLUSH_CYC + 1);
    localparam logic [FW-1:0]      FLUSH_LAST = FW'(FLUSH_CYC - 1);
    localparam logic [FW-1:0]      FLUSH_ONE  = FW'(1);
    localparam logic [ADDR_BITS:0] LEN_ONE    = (ADDR_BITS+1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   base_q, base_d;
    logic [ADDR_BITS:0]     len_q, len_d;
    logic [ADDR_BITS:0]     idx_q, idx_d;
    logic [FW-1:0]          flush_q, flush_d;
    logic                   last_read;
    logic                   last_pass;
    logic                   rd_pend_q;

`ifdef SYSTOLIC_FEEDER_REPEAT_EN
    logic [3:0]             pass_q, pass_d;
    logic [3:0]             rep_q, rep_d;

    assign last_pass = (pass_q == rep_q);
`else
    assign last_pass = 1'b1;
`endif

    assign last_read = (idx_q == (len_q - LEN_ONE));

    // State, run parameters and counters; reset returns everything to an idle, empty run.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            flush_q <= '0;
`ifdef SYSTOLIC_FEEDER_REPEAT_EN
            pass_q  <= '0;
            rep_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            flush_q <= flush_d;
`ifdef SYSTOLIC_FEEDER_REPEAT_EN
            pass_q  <= pass_d;
            rep_q   <= rep_d;
`endif
        end
    end

    // Next-state and counter sequencing for start, read issue, pass repeat and flush.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        idx_d   = idx_q;
        flush_d = flush_q;
`ifdef SYSTOLIC_FEEDER_REPEAT_EN
        pass_d  = pass_q;
        rep_d   = rep_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_Start) begin
                    if (i_Len != '0) begin
                        base_d  = i_Base_Addr;
                        len_d   = i_Len;
                        idx_d   = '0;
                        state_d = FEED;
`ifdef SYSTOLIC_FEEDER_REPEAT_EN
                        pass_d  = '0;
                        rep_d   = i_Repeat;
`endif
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FEED: begin
                if (last_read) begin
                    idx_d = '0;
                    if (last_pass) begin
                        flush_d = '0;
                        state_d = FLUSH;
                    end else begin
`ifdef SYSTOLIC_FEEDER_REPEAT_EN
                        pass_d = pass_q + 4'd1;
`endif
                    end
                end else begin
                    idx_d = idx_q + LEN_ONE;
                end
            end
            FLUSH: begin
                if (flush_q == FLUSH_LAST) begin
                    state_d = DONE;
                end else begin
                    flush_d = flush_q + FLUSH_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read strobe and address follow the state directly so reset silences them immediately.
    always_comb begin
        o_Rd_En   = (state_q == FEED);
        o_Rd_Addr = '0;
        if (state_q == FEED) begin
            o_Rd_Addr = base_q + idx_q[ADDR_BITS-1:0];
        end
        o_Busy    = (state_q != IDLE);
        o_Done    = (state_q == DONE);
    end

    // Register returned buffer data one cycle after the read; everything else is an all-zero bubble.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rd_pend_q   <= 1'b0;
            o_Data_I_In <= '0;
            o_Valid     <= 1'b0;
        end else begin
            rd_pend_q   <= o_Rd_En;
            o_Valid     <= rd_pend_q;
            o_Data_I_In <= rd_pend_q ? i_Rd_Data : '0;
        end
    end

endmodule

// File: tb/tb_systolic_feeder_i.sv
// tb/tb_systolic_feeder_i.sv - scoreboard bench for systolic_feeder_i
`ifndef PE_ROW
`define PE_ROW 8
`endif
`ifndef BIT_DATA
`define BIT_DATA 8
`endif

module tb_systolic_feeder_i;

    localparam int AB = 8;
    localparam int FL = 14;
    localparam int DW = `PE_ROW * `BIT_DATA;

    logic            CLK = 1'b0;
    logic            RSTn = 1'b0;
    logic            i_Start = 1'b0;
    logic [AB-1:0]   i_Base_Addr = '0;
    logic [AB:0]     i_Len = '0;
`ifdef SYSTOLIC_FEEDER_REPEAT_EN
    logic [3:0]      i_Repeat = '0;
`endif
    logic            o_Rd_En;
    logic [AB-1:0]   o_Rd_Addr;
    logic [DW-1:0]   i_Rd_Data;
    logic [DW-1:0]   o_Data_I_In;
    logic            o_Valid;
    logic            o_Busy;
    logic            o_Done;

    logic [DW-1:0]   mem [0:255];
    int              cyc = 0;

    int              n_cmp = 0;
    int              n_err = 0;
    logic [AB-1:0]   exp_addr [$];
    logic [DW-1:0]   exp_data [$];
    int              valid_seen;
    int              first_valid;
    int              last_valid;
    int              done_cnt;
    int              done_cyc;

    systolic_feeder_i #(.ADDR_BITS(AB), .FLUSH_LEN(FL)) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .i_Start     (i_Start),
        .i_Base_Addr (i_Base_Addr),
        .i_Len       (i_Len),
`ifdef SYSTOLIC_FEEDER_REPEAT_EN
        .i_Repeat    (i_Repeat),
`endif
        .o_Rd_En     (o_Rd_En),
        .o_Rd_Addr   (o_Rd_Addr),
        .i_Rd_Data   (i_Rd_Data),
        .o_Data_I_In (o_Data_I_In),
        .o_Valid     (o_Valid),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Buffer model: data one cycle after the read strobe, noise otherwise.
    always @(posedge CLK) begin
        if (o_Rd_En) i_Rd_Data <= mem[o_Rd_Addr];
        else         i_Rd_Data <= {$urandom, $urandom};
    end

    task automatic monitor();
        logic [AB-1:0] ea;
        logic [DW-1:0] ed;
        forever begin
            @(negedge CLK);
            if (RSTn) begin
                if (o_Rd_En) begin
                    n_cmp++;
                    if (exp_addr.size() == 0) begin
                        n_err++;
                        $display("FAIL extra_read: addr=%0d at cyc %0d, required no read", o_Rd_Addr, cyc);
                    end else begin
                        ea = exp_addr.pop_front();
                        if (o_Rd_Addr !== ea) begin
                            n_err++;
                            $display("FAIL rd_addr: got %0d, required %0d (cyc %0d)", o_Rd_Addr, ea, cyc);
                        end
                    end
                end
                n_cmp++;
                if (o_Valid) begin
                    if (valid_seen == 0) first_valid = cyc;
                    last_valid = cyc;
                    valid_seen++;
                    if (exp_data.size() == 0) begin
                        n_err++;
                        $display("FAIL extra_valid: data=%h at cyc %0d, required none", o_Data_I_In, cyc);
                    end else begin
                        ed = exp_data.pop_front();
                        if (o_Data_I_In !== ed) begin
                            n_err++;
                            $display("FAIL data: got %h, required %h (cyc %0d)", o_Data_I_In, ed, cyc);
                        end
                    end
                end else if (o_Data_I_In !== '0) begin
                    n_err++;
                    $display("FAIL bubble: got %h, required 0 (cyc %0d)", o_Data_I_In, cyc);
                end
                if (o_Done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    endtask

    function automatic int passes(input int rep);
`ifdef SYSTOLIC_FEEDER_REPEAT_EN
        return rep + 1;
`else
        return (rep >= 0) ? 1 : 1;
`endif
    endfunction

    task automatic do_start(input int base, input int len, input int rep, output int s);
        int a;
        @(negedge CLK);
        valid_seen  = 0;
        first_valid = -1;
        last_valid  = -1;
        done_cnt    = 0;
        done_cyc    = -1;
        for (int p = 0; p < passes(rep); p++) begin
            for (int k = 0; k < len; k++) begin
                a = (base + k) % 256;
                exp_addr.push_back(a[AB-1:0]);
                exp_data.push_back(mem[a]);
            end
        end
        i_Start     = 1'b1;
        i_Base_Addr = base[AB-1:0];
        i_Len       = len[AB:0];
`ifdef SYSTOLIC_FEEDER_REPEAT_EN
        i_Repeat    = rep[3:0];
`endif
        @(posedge CLK);
        #1;
        s = cyc;
        i_Start = 1'b0;
    endtask

    task automatic wait_done(input int s, input int len, input int rep, input string tag);
        int n;
        int exp_done;
        int t;
        n = len * passes(rep);
        exp_done = (len == 0) ? s : s + n + FL + 2;
        t = 0;
        while (done_cnt == 0 && t < n + 200) begin
            @(posedge CLK);
            #1;
            t++;
        end
        n_cmp++;
        if (done_cnt == 0) begin
            n_err++;
            $display("FAIL %s_timeout: no o_Done after %0d cycles, required one", tag, t);
            exp_addr.delete();
            exp_data.delete();
            return;
        end
        n_cmp++;
        if (done_cyc !== exp_done) begin
            n_err++;
            $display("FAIL %s_done_cyc: got %0d, required %0d", tag, done_cyc, exp_done);
        end
        n_cmp++;
        if ({o_Busy, o_Done} !== 2'b00) begin
            n_err++;
            $display("FAIL %s_idle_after: busy/done=%b, required 00", tag, {o_Busy, o_Done});
        end
        if (n > 0) begin
            n_cmp++;
            if (first_valid !== s + 2) begin
                n_err++;
                $display("FAIL %s_first_valid: got %0d, required %0d", tag, first_valid, s + 2);
            end
            n_cmp++;
            if (last_valid !== s + n + 1) begin
                n_err++;
                $display("FAIL %s_last_valid: got %0d, required %0d", tag, last_valid, s + n + 1);
            end
        end
        n_cmp++;
        if (valid_seen !== n) begin
            n_err++;
            $display("FAIL %s_valid_count: got %0d, required %0d", tag, valid_seen, n);
        end
        n_cmp++;
        if (exp_addr.size() != 0 || exp_data.size() != 0) begin
            n_err++;
            $display("FAIL %s_missing: %0d reads / %0d vectors outstanding, required 0", tag, exp_addr.size(), exp_data.size());
        end
        repeat (4) @(posedge CLK);
        #1;
        n_cmp++;
        if (done_cnt !== 1) begin
            n_err++;
            $display("FAIL %s_done_count: got %0d, required 1", tag, done_cnt);
        end
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        n_cmp++;
        if ({o_Rd_En, o_Valid, o_Busy, o_Done} !== 4'b0 || o_Rd_Addr !== '0 || o_Data_I_In !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: en/valid/busy/done=%b addr=%0d data=%h, required all 0",
                     {o_Rd_En, o_Valid, o_Busy, o_Done}, o_Rd_Addr, o_Data_I_In);
        end
        RSTn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            n_cmp++;
            if ({o_Rd_En, o_Valid, o_Busy, o_Done} !== 4'b0 || o_Data_I_In !== '0) begin
                n_err++;
                $display("FAIL idle_outputs: en/valid/busy/done=%b data=%h, required all 0",
                         {o_Rd_En, o_Valid, o_Busy, o_Done}, o_Data_I_In);
            end
        end
    endtask

    task automatic test_basic();
        int s;
        mem[10] = 64'hAAAA_0000_0000_000A;
        mem[11] = 64'hBBBB_0000_0000_000B;
        mem[12] = 64'hCCCC_0000_0000_000C;
        mem[13] = 64'hDDDD_0000_0000_000D;
        do_start(10, 4, 0, s);
        wait_done(s, 4, 0, "basic");
    endtask

    task automatic test_wrap_full();
        int s;
        do_start(254, 4, 0, s);
        wait_done(s, 4, 0, "wrap");
        do_start(0, 256, 0, s);
        wait_done(s, 256, 0, "full");
        do_start(200, 256, 0, s);
        wait_done(s, 256, 0, "full_wrap");
    endtask

    task automatic test_zero_len();
        int s;
        do_start(33, 0, 0, s);
        wait_done(s, 0, 0, "zero_len");
    endtask

    task automatic test_ignored_start();
        int s;
        do_start(20, 8, 0, s);
        repeat (3) @(negedge CLK);
        i_Start     = 1'b1;
        i_Base_Addr = 8'd100;
        i_Len       = 9'd5;
        repeat (2) @(negedge CLK);
        i_Start     = 1'b0;
        wait_done(s, 8, 0, "ignored_start");
    endtask

    task automatic test_back_to_back();
        int s;
        do_start(40, 3, 0, s);
        wait_done(s, 3, 0, "b2b_first");
        do_start(41, 5, 0, s);
        wait_done(s, 5, 0, "b2b_second");
    endtask

    task automatic test_reset_mid();
        int s;
        int v;
        int t;
        do_start(0, 8, 0, s);
        v = 0;
        t = 0;
        while (v < 3 && t < 50) begin
            @(posedge CLK);
            #2;
            if (o_Valid) v++;
            t++;
        end
        n_cmp++;
        if (v < 3) begin
            n_err++;
            $display("FAIL midrst_wait: saw %0d valid cycles, required 3", v);
        end
        RSTn = 1'b0;
        #1;
        n_cmp++;
        if ({o_Rd_En, o_Valid, o_Busy, o_Done} !== 4'b0 || o_Rd_Addr !== '0 || o_Data_I_In !== '0) begin
            n_err++;
            $display("FAIL midrst_outputs: en/valid/busy/done=%b addr=%0d data=%h, required all 0",
                     {o_Rd_En, o_Valid, o_Busy, o_Done}, o_Rd_Addr, o_Data_I_In);
        end
        exp_addr.delete();
        exp_data.delete();
        @(negedge CLK);
        RSTn = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            n_cmp++;
            if ({o_Rd_En, o_Busy, o_Done} !== 3'b0) begin
                n_err++;
                $display("FAIL midrst_idle: en/busy/done=%b, required 000", {o_Rd_En, o_Busy, o_Done});
            end
        end
        do_start(0, 2, 0, s);
        wait_done(s, 2, 0, "after_rst");
    endtask

`ifdef SYSTOLIC_FEEDER_REPEAT_EN
    task automatic test_repeat();
        int s;
        do_start(5, 3, 2, s);
        wait_done(s, 3, 2, "repeat");
        do_start(0, 0, 3, s);
        wait_done(s, 0, 3, "repeat_zero");
    endtask
`endif

    initial begin
        logic [63:0] r;
        for (int i = 0; i < 256; i++) begin
            r = {$urandom, $urandom};
            mem[i] = r[DW-1:0] | 1;
        end
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_wrap_full();
        test_zero_len();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
`ifdef SYSTOLIC_FEEDER_REPEAT_EN
        test_repeat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
